// File: rtl/core_mem_arbiter.sv
// Two-requester (L1I fetch / L1D load-store) arbiter in front of one memory port, one transaction in flight.
// Optional WAIT-state timeout abort enabled by defining CORE_ARB_TIMEOUT_EN.
module core_mem_arbiter #(
  parameter int         FIX_PRIO = 0,
  parameter logic [7:0] TMO_CYC  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_val,
  input  logic [31:0] i_req_addr,
  output logic        i_req_rdy,
  output logic        i_ack_val,
  output logic [31:0] i_ack_rdata,
  input  logic        d_req_val,
  input  logic [31:0] d_req_addr,
  input  logic [2:0]  d_req_cop,
  input  logic [2:0]  d_req_size,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_rdy,
  output logic        d_ack_val,
  output logic [31:0] d_ack_rdata,
  output logic        m_req_val,
  output logic [31:0] m_req_addr,
  output logic [2:0]  m_req_cop,
  output logic [2:0]  m_req_size,
  output logic [31:0] m_req_wdata,
  output logic        m_req_id,
  input  logic        m_req_rdy,
  input  logic        m_ack_val,
  input  logic [31:0] m_ack_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_id;
  logic        id_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  cop_q;
  logic [2:0]  size_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        grant_d;
  logic        accept;
  logic        tmo_hit;
  logic        wait_done;

  // D wins a tie under fixed priority, or when I was served last.
  assign grant_d   = d_req_val & (~i_req_val | (FIX_PRIO != 0) | ~last_id);
  assign accept    = (state == IDLE) & (i_req_val | d_req_val);
  assign wait_done = (state == WAIT) & (m_ack_val | tmo_hit);

`ifdef CORE_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_q;

  assign tmo_hit = (state == WAIT) & ~m_ack_val & (tmo_cnt == TMO_CYC);
  assign err     = (state == RESP) & tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      if (state == REQ && m_req_rdy) tmo_cnt <= 8'd0;
      else if (state == WAIT)        tmo_cnt <= tmo_cnt + 8'd1;
      if (wait_done)                 tmo_q   <= tmo_hit;
      else if (state == RESP)        tmo_q   <= 1'b0;
    end
  end
`else
  // The limit only matters when the timeout is built in.
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = REQ;
      REQ:     if (m_req_rdy) state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_req_rdy = accept & ~grant_d;
    d_req_rdy = accept & grant_d;
    m_req_val = (state == REQ);
    i_ack_val = (state == RESP) & ~id_q;
    d_ack_val = (state == RESP) & id_q;
    busy      = (state != IDLE);
  end

  assign m_req_addr  = addr_q;
  assign m_req_cop   = cop_q;
  assign m_req_size  = size_q;
  assign m_req_wdata = wdata_q;
  assign m_req_id    = id_q;
  assign i_ack_rdata = i_rdata_q;
  assign d_ack_rdata = d_rdata_q;

  // Request latch; I side is always a word read with no write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id   <= 1'b0;
      id_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cop_q     <= 3'd0;
      size_q    <= 3'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        id_q    <= grant_d;
        last_id <= grant_d;
        addr_q  <= grant_d ? d_req_addr  : i_req_addr;
        cop_q   <= grant_d ? d_req_cop   : 3'd0;
        size_q  <= grant_d ? d_req_size  : 3'd2;
        wdata_q <= grant_d ? d_req_wdata : 32'd0;
      end
      // Response data lands in the owner's register so the other side keeps its last value.
      if (wait_done) begin
        if (id_q) d_rdata_q <= m_ack_val ? m_ack_rdata : 32'd0;
        else      i_rdata_q <= m_ack_val ? m_ack_rdata : 32'd0;
      end
    end
  end

endmodule
